// File: rtl/xfer_timepulse_sequencer.sv
// Memory-cycle timepulse sequencer: T01..T(NTP) train with CT/RT/WT phases and
// round-robin register-transfer arbitration driving active-low read/write pulses.
module xfer_timepulse_sequencer #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned NTP  = 12
) (
    input  logic                SIM_CLK,
    input  logic                SIM_RST,
    input  logic                RUN,
    input  logic [NREQ-1:0]     REQ,
    input  logic [3*NREQ-1:0]   REQ_SRC,
    input  logic [3*NREQ-1:0]   REQ_DST,
    output logic [NREQ-1:0]     GNT,
    output logic [NTP-1:0]      T_n,
    output logic                CT_n,
    output logic                RT_n,
    output logic                WT_n,
    output logic                RA_n,
    output logic                RL_n,
    output logic                RQ_n,
    output logic                RG_n,
    output logic                RB_n,
    output logic                RZ_n,
    output logic                RU_n,
    output logic                WA_n,
    output logic                WL_n,
    output logic                WQ_n,
    output logic                WG_n,
    output logic                WB_n,
    output logic                WZ_n,
    output logic                WY_n,
    output logic                MCT_END,
    output logic                BUSY
);

    localparam int unsigned TPW = $clog2(NTP);
    localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TPW-1:0] TP_LAST = TPW'(NTP - 1);
    localparam logic [PW-1:0]  PTR_LAST = PW'(NREQ - 1);

    typedef enum logic {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [TPW-1:0]  tp_q, tp_d;
    logic [1:0]      ph_q, ph_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [2:0]      src_q, src_d;
    logic [2:0]      dst_q, dst_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NTP-1:0]  t_n_q, t_n_d;
    logic            ct_n_q, ct_n_d;
    logic            rt_n_q, rt_n_d;
    logic            wt_n_q, wt_n_d;
    logic [6:0]      rd_n_q, rd_n_d;
    logic [6:0]      wr_n_q, wr_n_d;
    logic            mct_end_q, mct_end_d;
    logic            busy_q, busy_d;

    logic            arb_found;
    logic [PW-1:0]   arb_win;
    logic [2:0]      arb_src;
    logic [2:0]      arb_dst;
    logic            enter_ph0;
    logic            run_d;
    int unsigned     scan_idx;

    // Round-robin scan of REQ starting at the pointer; first set request wins.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = (32'(ptr_q) + k) % NREQ;
            if (!arb_found && REQ[PW'(scan_idx)]) begin
                arb_found = 1'b1;
                arb_win   = PW'(scan_idx);
            end
        end
        arb_src = 3'(REQ_SRC >> (3 * 32'(arb_win)));
        arb_dst = 3'(REQ_DST >> (3 * 32'(arb_win)));
    end

    // Next state; outputs are decoded from the next state so they register in step with it.
    always_comb begin
        state_d   = state_q;
        tp_d      = tp_q;
        ph_d      = ph_q;
        ptr_d     = ptr_q;
        src_d     = src_q;
        dst_d     = dst_q;
        gnt_d     = '0;
        enter_ph0 = 1'b0;

        case (state_q)
            ST_HALT: begin
                if (RUN) begin
                    state_d   = ST_RUN;
                    tp_d      = '0;
                    ph_d      = 2'd0;
                    enter_ph0 = 1'b1;
                end
            end
            ST_RUN: begin
                if (ph_q != 2'd3) begin
                    ph_d = ph_q + 2'd1;
                end else begin
                    ph_d = 2'd0;
                    if (tp_q == TP_LAST) begin
                        if (RUN) begin
                            tp_d      = '0;
                            enter_ph0 = 1'b1;
                        end else begin
                            state_d = ST_HALT;
                            tp_d    = '0;
                        end
                    end else begin
                        tp_d      = tp_q + TPW'(1);
                        enter_ph0 = 1'b1;
                    end
                end
            end
            default: state_d = ST_HALT;
        endcase

        if (enter_ph0) begin
            if (arb_found) begin
                gnt_d = NREQ'(1) << arb_win;
                src_d = arb_src;
                dst_d = arb_dst;
                ptr_d = (arb_win == PTR_LAST) ? '0 : arb_win + PW'(1);
            end else begin
                src_d = 3'd0;
                dst_d = 3'd0;
            end
        end
        if (state_d == ST_HALT) begin
            src_d = 3'd0;
            dst_d = 3'd0;
        end

        run_d     = (state_d == ST_RUN);
        t_n_d     = run_d ? ~(NTP'(1) << tp_d) : '1;
        ct_n_d    = !(run_d && ph_d == 2'd1);
        rt_n_d    = !(run_d && ph_d[1]);
        wt_n_d    = !(run_d && ph_d == 2'd3);
        mct_end_d = run_d && tp_d == TP_LAST && ph_d == 2'd3;
        busy_d    = run_d;
        rd_n_d    = (src_d != 3'd0) ? ~(7'(1) << (src_d - 3'd1)) : '1;
        wr_n_d    = (dst_d != 3'd0) ? ~(7'(1) << (dst_d - 3'd1)) : '1;
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state_q   <= ST_HALT;
            tp_q      <= '0;
            ph_q      <= 2'd0;
            ptr_q     <= '0;
            src_q     <= 3'd0;
            dst_q     <= 3'd0;
            gnt_q     <= '0;
            t_n_q     <= '1;
            ct_n_q    <= 1'b1;
            rt_n_q    <= 1'b1;
            wt_n_q    <= 1'b1;
            rd_n_q    <= '1;
            wr_n_q    <= '1;
            mct_end_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tp_q      <= tp_d;
            ph_q      <= ph_d;
            ptr_q     <= ptr_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            gnt_q     <= gnt_d;
            t_n_q     <= t_n_d;
            ct_n_q    <= ct_n_d;
            rt_n_q    <= rt_n_d;
            wt_n_q    <= wt_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            mct_end_q <= mct_end_d;
            busy_q    <= busy_d;
        end
    end

    assign GNT     = gnt_q;
    assign T_n     = t_n_q;
    assign CT_n    = ct_n_q;
    assign RT_n    = rt_n_q;
    assign WT_n    = wt_n_q;
    assign RA_n    = rd_n_q[0];
    assign RL_n    = rd_n_q[1];
    assign RQ_n    = rd_n_q[2];
    assign RG_n    = rd_n_q[3];
    assign RB_n    = rd_n_q[4];
    assign RZ_n    = rd_n_q[5];
    assign RU_n    = rd_n_q[6];
    assign WA_n    = wr_n_q[0];
    assign WL_n    = wr_n_q[1];
    assign WQ_n    = wr_n_q[2];
    assign WG_n    = wr_n_q[3];
    assign WB_n    = wr_n_q[4];
    assign WZ_n    = wr_n_q[5];
    assign WY_n    = wr_n_q[6];
    assign MCT_END = mct_end_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_xfer_timepulse_sequencer.sv
// Bench for xfer_timepulse_sequencer: directed steps plus randomized requests,
// compared every clock against a clock-count reference model.
module tb_xfer_timepulse_sequencer;

    localparam int unsigned NREQ = 3;
    localparam int unsigned NTP  = 12;
    localparam int unsigned SW   = 3 * NREQ;
    localparam int          CYC  = 4 * NTP;

    logic            SIM_CLK = 1'b0;
    logic            SIM_RST = 1'b0;
    logic            RUN     = 1'b0;
    logic [NREQ-1:0] REQ     = '0;
    logic [SW-1:0]   REQ_SRC;
    logic [SW-1:0]   REQ_DST;
    logic [NREQ-1:0] GNT;
    logic [NTP-1:0]  T_n;
    logic CT_n, RT_n, WT_n;
    logic RA_n, RL_n, RQ_n, RG_n, RB_n, RZ_n, RU_n;
    logic WA_n, WL_n, WQ_n, WG_n, WB_n, WZ_n, WY_n;
    logic MCT_END, BUSY;

    int src_a[NREQ];
    int dst_a[NREQ];

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Reference model: running flag, clock index within the memory cycle, pointer, latched transfer.
    bit m_run;
    int m_cnt, m_ptr, m_src, m_dst, m_gnt;
    int gq[$];

    xfer_timepulse_sequencer #(.NREQ(NREQ), .NTP(NTP)) dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .RUN(RUN), .REQ(REQ),
        .REQ_SRC(REQ_SRC), .REQ_DST(REQ_DST), .GNT(GNT), .T_n(T_n),
        .CT_n(CT_n), .RT_n(RT_n), .WT_n(WT_n),
        .RA_n(RA_n), .RL_n(RL_n), .RQ_n(RQ_n), .RG_n(RG_n), .RB_n(RB_n), .RZ_n(RZ_n), .RU_n(RU_n),
        .WA_n(WA_n), .WL_n(WL_n), .WQ_n(WQ_n), .WG_n(WG_n), .WB_n(WB_n), .WZ_n(WZ_n), .WY_n(WY_n),
        .MCT_END(MCT_END), .BUSY(BUSY)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    always_comb begin
        REQ_SRC = '0;
        REQ_DST = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            REQ_SRC = REQ_SRC | (SW'(src_a[i] & 7) << (3 * i));
            REQ_DST = REQ_DST | (SW'(dst_a[i] & 7) << (3 * i));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_cnt = 0; m_ptr = 0; m_src = 0; m_dst = 0; m_gnt = -1;
    endtask

    // Applies the rules for one rising edge using the inputs as they stand before it.
    task automatic model_edge();
        bit arb = 0;
        m_gnt = -1;
        if (!m_run) begin
            if (RUN) begin m_run = 1; m_cnt = 0; arb = 1; end
        end else if (m_cnt == CYC - 1) begin
            if (RUN) begin m_cnt = 0; arb = 1; end
            else m_run = 0;
        end else begin
            m_cnt++;
            arb = (m_cnt % 4 == 0);
        end
        if (arb) begin
            m_src = 0; m_dst = 0;
            for (int k = 0; k < int'(NREQ); k++) begin
                int idx = (m_ptr + k) % int'(NREQ);
                if (m_gnt < 0 && ((REQ >> idx) & NREQ'(1)) != 0) m_gnt = idx;
            end
            if (m_gnt >= 0) begin
                m_src = src_a[m_gnt];
                m_dst = dst_a[m_gnt];
                m_ptr = (m_gnt + 1) % int'(NREQ);
            end
        end
        if (!m_run) begin m_src = 0; m_dst = 0; end
    endtask

    task automatic compare_all();
        logic [NTP-1:0]  e_t;
        logic [NREQ-1:0] e_g;
        logic [6:0]      e_rd, e_wr;
        int ph;
        ph   = m_cnt % 4;
        e_t  = m_run ? ~(NTP'(1) << (m_cnt / 4)) : '1;
        e_g  = (m_gnt >= 0) ? (NREQ'(1) << m_gnt) : '0;
        e_rd = (m_run && m_src != 0) ? ~(7'(1) << (m_src - 1)) : '1;
        e_wr = (m_run && m_dst != 0) ? ~(7'(1) << (m_dst - 1)) : '1;
        chk("T_n", 32'(T_n), 32'(e_t));
        chk("CT_n", 32'(CT_n), 32'(!(m_run && ph == 1)));
        chk("RT_n", 32'(RT_n), 32'(!(m_run && ph >= 2)));
        chk("WT_n", 32'(WT_n), 32'(!(m_run && ph == 3)));
        chk("GNT", 32'(GNT), 32'(e_g));
        chk("rd_pulses", 32'({RU_n, RZ_n, RB_n, RG_n, RQ_n, RL_n, RA_n}), 32'(e_rd));
        chk("wr_pulses", 32'({WY_n, WZ_n, WB_n, WG_n, WQ_n, WL_n, WA_n}), 32'(e_wr));
        chk("MCT_END", 32'(MCT_END), 32'(m_run && m_cnt == CYC - 1));
        chk("BUSY", 32'(BUSY), 32'(m_run));
    endtask

    task automatic step();
        model_edge();
        @(posedge SIM_CLK);
        #1;
        compare_all();
        for (int i = 0; i < int'(NREQ); i++) if (GNT[i]) gq.push_back(i);
    endtask

    task automatic wait_cnt(input int modn, input int val, input string tag);
        int i = 0;
        while (!(m_run && (m_cnt % modn) == val) && i < 200) begin step(); i++; end
        chk(tag, 32'(m_run && (m_cnt % modn) == val), 32'd1);
    endtask

    initial begin
        int cnt;
        int rr_exp[6];
        rr_exp = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < int'(NREQ); i++) begin src_a[i] = 0; dst_a[i] = 0; end
        model_reset();

        // Reset state, then idle in HALT with requests present.
        @(posedge SIM_CLK); #1;
        compare_all();
        SIM_RST = 1'b1;
        REQ = 3'b101;
        for (int i = 0; i < 3; i++) step();
        REQ = '0;

        // Free-running timepulse train, no requests: two full memory cycles.
        RUN = 1'b1;
        cnt = 0;
        for (int i = 0; i < 2 * CYC; i++) begin step(); if (MCT_END) cnt++; end
        chk("mct_end_count", 32'(cnt), 32'd2);

        // Single A->B transfer from requester 1, dropped after grant.
        wait_cnt(4, 1, "reach_ph1");
        REQ = 3'b010; src_a[1] = 1; dst_a[1] = 5;
        cnt = 0;
        while (m_gnt != 1 && cnt < 8) begin step(); cnt++; end
        chk("gnt1", 32'(GNT), 32'b010);
        REQ = '0;
        cnt = (!RA_n && !WB_n) ? 1 : 0;
        for (int i = 0; i < 11; i++) begin step(); if (!RA_n && !WB_n) cnt++; end
        chk("ra_wb_width", 32'(cnt), 32'd4);

        // RUN dropped at T05 completes the cycle, then halts.
        wait_cnt(CYC, 16, "reach_tp5");
        RUN = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100 && m_run; i++) begin step(); if (MCT_END) cnt++; end
        chk("mct_before_halt", 32'(cnt), 32'd1);
        chk("halt_busy", 32'(BUSY), 32'd0);
        chk("halt_tn", 32'(T_n), 32'hFFF);

        // Reset in T07 ph2 during a Z->Y transfer, then restart with all requesting.
        RUN = 1'b1;
        wait_cnt(CYC, 22, "reach_tp6_ph2");
        REQ = 3'b100; src_a[2] = 6; dst_a[2] = 7;
        for (int i = 0; i < 4; i++) step();
        chk("rz_wy_low", 32'({RZ_n, WY_n}), 32'd0);
        REQ = '0;
        #2 SIM_RST = 1'b0;
        #1 model_reset();
        compare_all();
        REQ = 3'b111;
        for (int i = 0; i < int'(NREQ); i++) begin src_a[i] = 4; dst_a[i] = 3; end
        #2 SIM_RST = 1'b1;
        gq.delete();
        step();
        chk("restart_t01", 32'(T_n), 32'hFFE);
        for (int i = 0; i < 23; i++) step();
        chk("rr_count", 32'(gq.size()), 32'd6);
        for (int i = 0; i < 6 && i < gq.size(); i++) chk("rr_order", 32'(gq[i]), 32'(rr_exp[i]));

        // Request raised at ph2 waits for the next ph0; null SRC/DST grant drives no pulse.
        REQ = '0;
        for (int i = 0; i < 4; i++) step();
        wait_cnt(4, 2, "reach_ph2");
        REQ = 3'b001; src_a[0] = 0; dst_a[0] = 0;
        step();
        chk("no_gnt_ph3", 32'(GNT), 32'd0);
        step();
        chk("gnt_ph0", 32'(GNT), 32'b001);
        chk("null_pulses", 32'({RA_n, RL_n, RQ_n, RG_n, RB_n, RZ_n, RU_n,
                                WA_n, WL_n, WQ_n, WG_n, WB_n, WZ_n, WY_n}), 32'h3FFF);
        REQ = '0;

        // Randomized requesters honouring the hold-until-granted handshake.
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (((REQ >> i) & NREQ'(1)) == 0 && $urandom_range(0, 3) == 0) begin
                    REQ = REQ | (NREQ'(1) << i);
                    src_a[i] = int'($urandom_range(0, 7));
                    dst_a[i] = int'($urandom_range(0, 7));
                end
            end
            if ($urandom_range(0, 149) == 0) RUN = ~RUN;
            step();
            if (m_gnt >= 0) begin
                if ($urandom_range(0, 1) == 0) REQ = REQ & ~(NREQ'(1) << m_gnt);
                else begin
                    src_a[m_gnt] = int'($urandom_range(0, 7));
                    dst_a[m_gnt] = int'($urandom_range(0, 7));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/xfer_timepulse_sequencer.md
Name: xfer_timepulse_sequencer

Overview:
- Generates the memory-cycle timepulse train (T01..T12) and, within each timepulse, the CT/RT/WT strobe phases.
- Arbitrates register-transfer requests from NREQ requesters, one transfer per timepulse.
- Drives the active-low read/write control pulses (RA_n..WY_n) consumed by the service-gate block, which ANDs them with RT_n/WT_n/CT_n.
- Sits between instruction/counter/channel sequencing logic and the service gates.

Parameters:
- NREQ, 3, number of requesters (1..8); index 0 has the highest initial priority.
- NTP, 12, timepulses per memory cycle (2..16).

Ports:
- SIM_CLK  input  1  system clock; all state changes on the rising edge.
- SIM_RST  input  1  reset; asynchronous assert, active-low.
- RUN  input  1  sequencer enable, level-sensitive.
- REQ  input  NREQ  per-requester transfer request, level; held until granted.
- REQ_SRC  input  3*NREQ  per-requester source code, packed with requester i at bits [3i+2:3i].
- REQ_DST  input  3*NREQ  per-requester destination code, packed the same way.
- GNT  output  NREQ  one-clock grant pulse, one-hot.
- T_n  output  NTP  active-low one-hot timepulse; bit k corresponds to T(k+1).
- CT_n  output  1  clear strobe, active-low.
- RT_n  output  1  read strobe, active-low.
- WT_n  output  1  write strobe, active-low.
- RA_n, RL_n, RQ_n, RG_n, RB_n, RZ_n, RU_n  output  1 each  read control pulses, active-low.
- WA_n, WL_n, WQ_n, WG_n, WB_n, WZ_n, WY_n  output  1 each  write control pulses, active-low.
- MCT_END  output  1  one-clock pulse on the last tick of T(NTP).
- BUSY  output  1  high while a memory cycle is in progress.

Behaviour:
- Source codes: 0 none, 1 A, 2 L, 3 Q, 4 G, 5 B, 6 Z, 7 U.
- Destination codes: 0 none, 1 A, 2 L, 3 Q, 4 G, 5 B, 6 Z, 7 Y. Code 0 drives no pulse.
- Reset (SIM_RST low, immediate and asynchronous): state HALT; T_n all 1; CT_n, RT_n, WT_n = 1; all R*/W* pulses = 1; GNT = 0; MCT_END = 0; BUSY = 0; round-robin pointer = 0.
- Reset asserted mid-cycle aborts the cycle with no completion pulse.
- States:
  - HALT: entered from reset.
  - RUNNING: tracks timepulse tp (1..NTP) and phase ph (0..3).
- HALT -> RUNNING when RUN=1 at an edge. The first RUNNING cycle is tp=1, ph=0.
- RUNNING advance: ph 0->1->2->3. From ph=3, tp increments and ph returns to 0. One timepulse is 4 clocks; one memory cycle is 4*NTP clocks.
- End of cycle at tp=NTP, ph=3:
  - RUN=1: wrap to tp=1, ph=0, with no gap.
  - RUN=0: go to HALT.
  - RUN is sampled only here. A mid-cycle drop of RUN completes the cycle.
- T_n: bit tp-1 is low for all 4 phases of timepulse tp; all bits high in HALT.
- Strobes:
  - ph1: CT_n=0.
  - ph2: RT_n=0.
  - ph3: RT_n=0 and WT_n=0.
  - ph0: all strobes high.
  - Strobes run every timepulse, including idle ones.
- Arbitration, ph0 of every timepulse:
  - Round-robin scan of REQ starting at the pointer.
  - The first set REQ is the winner. GNT[winner]=1 for exactly that ph0 clock.
  - The winner's SRC/DST are latched, and its pulses are driven low for ph0..ph3 of that timepulse. Pulses change only at ph0.
  - The pointer moves to winner+1 (mod NREQ).
  - If no request is set: no grant, pointer unchanged, all pulses high.
- Handshake: a requester may drop REQ or change SRC/DST the clock after its GNT. A REQ still high after GNT counts as a new request at the next ph0.
- Requests arriving at ph1..ph3 wait for the next ph0. Requests are ignored in HALT.
- MCT_END=1 at tp=NTP, ph=3. BUSY=1 in every RUNNING state.
- Outputs are registered with no combinational path from inputs. GNT is also registered, asserted in the ph0 clock.

Test Plan:
- Reset then RUN=1 held, no REQ -> T_n cycles 0xFFE..0x7FF in 4-clock steps; CT/RT/WT lows at ph1/ph2/ph3; MCT_END every 48 clocks; all pulses high.
- REQ[1]=1, SRC=1 (A), DST=5 (B) -> GNT[1] at ph0 of the next timepulse; RA_n=0 and WB_n=0 for exactly 4 clocks; REQ dropped after GNT -> no further pulses.
- REQ=3'b111 held, all SRC=4, DST=3 -> grants 0,1,2,0,1,2 on successive timepulses, each grant one clock.
- RUN dropped at tp=5 -> cycle runs through T12 ph3, MCT_END pulses, then HALT with BUSY=0 and T_n=0xFFF.
- SIM_RST asserted at tp=7, ph2 during an RZ_n/WY_n transfer -> all outputs high asynchronously; after release with RUN=1, restart at T01 ph0 and pointer=0.
- REQ rises at ph2 -> no GNT until the following ph0; SRC=0, DST=0 grant -> GNT pulses, no control pulse low.
